// File: rtl/mpc_axil_port_demux_if.sv
// rtl/mpc_axil_port_demux_if.sv - AXI4-Lite slave-side bundle for the port demux
// aruser carries the read byte enables from the PCI target bridge.
interface mpc_axil_port_demux_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  aruser;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready,
           arvalid, araddr, aruser, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
           arvalid, araddr, aruser, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/mpc_axil_port_demux.sv
// rtl/mpc_axil_port_demux.sv - AXI4-Lite to per-port req/ack register bus splitter
// One transaction in flight; decode miss or ack timeout answers SLVERR.
module mpc_axil_port_demux #(
  parameter int PORT_NUM = 4,
  parameter int ADDR_LSB = 10,
  parameter int TIMEOUT  = 255
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  mpc_axil_port_demux_if.slave     axi_s,
  output logic [PORT_NUM-1:0]      port_req_o,
  output logic                     port_we_o,
  output logic [ADDR_LSB-1:0]      port_addr_o,
  output logic [31:0]              port_wdata_o,
  output logic [3:0]               port_be_o,
  input  logic [PORT_NUM-1:0]      port_ack_i,
  input  logic [PORT_NUM*32-1:0]   port_rdata_i
);
  localparam int              IDXW       = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam logic [IDXW:0]   PORT_NUM_W = (IDXW+1)'(PORT_NUM);
  localparam logic [15:0]     TO_LAST    = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, BRESP, RRESP} state_t;

  state_t                state_q, state_d;
  logic                  last_wr_q, last_wr_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [PORT_NUM-1:0]   req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_LSB-1:0]   addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  wr_win, rd_win, is_idle;
  logic [31:0]           hs_addr;
  logic [IDXW-1:0]       hs_idx;
  logic                  sel_ack;
  logic [31:0]           sel_rdata;
  logic                  unused_ok;

  // Contention alternates on last_wr so neither direction can starve the other.
  always_comb begin
    is_idle = (state_q == IDLE);
    wr_win  = axi_s.awvalid && axi_s.wvalid && (!axi_s.arvalid || !last_wr_q);
    rd_win  = axi_s.arvalid && !wr_win;
    hs_addr = wr_win ? axi_s.awaddr : axi_s.araddr;
    hs_idx  = hs_addr[ADDR_LSB+IDXW-1:ADDR_LSB];
  end

  assign axi_s.awready = is_idle && wr_win;
  assign axi_s.wready  = is_idle && wr_win;
  assign axi_s.arready = is_idle && rd_win;
  assign unused_ok     = ^{hs_addr[31:ADDR_LSB+IDXW], hs_addr[1:0]};

  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = 32'h0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (idx_q == IDXW'(i)) begin
        sel_ack   = port_ack_i[i];
        sel_rdata = port_rdata_i[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (wr_win || rd_win) begin
          idx_d   = hs_idx;
          we_d    = wr_win;
          addr_d  = {hs_addr[ADDR_LSB-1:2], 2'b00};
          wdata_d = wr_win ? axi_s.wdata : 32'h0;
          be_d    = wr_win ? axi_s.wstrb : axi_s.aruser;
          cnt_d   = 16'h0;
          if ({1'b0, hs_idx} < PORT_NUM_W) begin
            state_d = ACCESS;
            req_d   = PORT_NUM'(1) << hs_idx;
          end else if (wr_win) begin
            state_d  = BRESP;
            bvalid_d = 1'b1;
            bresp_d  = 2'b10;
          end else begin
            state_d  = RRESP;
            rvalid_d = 1'b1;
            rresp_d  = 2'b10;
            rdata_d  = 32'h0;
          end
        end
      end
      ACCESS: begin
        // An ack in the terminal timeout cycle still completes OKAY.
        if (sel_ack || cnt_q == TO_LAST) begin
          req_d   = '0;
          state_d = we_q ? BRESP : RRESP;
          if (we_q) begin
            bvalid_d = 1'b1;
            bresp_d  = sel_ack ? 2'b00 : 2'b10;
          end else begin
            rvalid_d = 1'b1;
            rresp_d  = sel_ack ? 2'b00 : 2'b10;
            rdata_d  = sel_ack ? sel_rdata : 32'h0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      BRESP: begin
        if (axi_s.bready) begin
          bvalid_d  = 1'b0;
          last_wr_d = 1'b1;
          state_d   = IDLE;
        end
      end
      RRESP: begin
        if (axi_s.rready) begin
          rvalid_d  = 1'b0;
          last_wr_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= 16'h0;
      req_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign port_req_o   = req_q;
  assign port_we_o    = we_q;
  assign port_addr_o  = addr_q;
  assign port_wdata_o = wdata_q;
  assign port_be_o    = be_q;
  assign axi_s.bvalid = bvalid_q;
  assign axi_s.bresp  = bresp_q;
  assign axi_s.rvalid = rvalid_q;
  assign axi_s.rresp  = rresp_q;
  assign axi_s.rdata  = rdata_q;
endmodule
